// File: rtl/keypad_scan_fifo.sv
// Matrix-keypad scanner: one-hot row drive, 2-flop column sync, press/release debounce, key-code FIFO.
// Latency: a code reaches the FIFO head two cycles after the debounce accept edge. key_valid rises with it.
// Backpressure: key_valid/key_ready pop. A press that arrives while the FIFO is full is dropped and sets sticky overflow.
//
// Ports:
//   clk_Teclado  block clock, rising edge
//   rst_n        asynchronous active-low reset
//   row_o        one-hot row drive, active-high
//   col_i        column sense, active-high, asynchronous
//   key_code     registered FIFO head, row*COLS+col
//   key_valid    FIFO non-empty
//   key_ready    the head is popped when key_valid && key_ready
//   overflow     sticky dropped-press flag. Setting it beats ovf_clr in the same cycle.
//   ovf_clr      synchronous clear of overflow
//   key_held     a debounced key is currently down
// Optional build macro: KEYPAD_TYPEMATIC_EN adds auto-repeat while a key is held.
module keypad_scan_fifo #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int FIFO_DEPTH   = 4,
  localparam int CODE_W      = $clog2(ROWS*COLS)
) (
  input  logic              clk_Teclado,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_o,
  input  logic [COLS-1:0]   col_i,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              key_held
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYC);
  localparam int AW = $clog2(FIFO_DEPTH);
  // row_o lags the row index by one cycle, and the synchroniser adds two more cycles.
  // For that reason, columns are trusted only from divider count 3 onwards.
  localparam int SETTLE_CYC = 3;
`ifdef KEYPAD_TYPEMATIC_EN
  localparam int TW         = $clog2(32*DEBOUNCE_CYC);
  localparam int REP_FIRST  = 32*DEBOUNCE_CYC - 1;
  localparam int REP_RELOAD = 16*DEBOUNCE_CYC;
`endif

  typedef enum logic [1:0] {ST_SCAN, ST_DEB_PRESS, ST_HELD, ST_DEB_REL} state_t;

  // Column synchroniser
  logic [COLS-1:0] sync1_q, col_s_q;

  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      col_s_q <= '0;
    end else begin
      sync1_q <= col_i;
      col_s_q <= sync1_q;
    end
  end

  // Scanner / debounce FSM
  state_t            state_q;
  logic [RW-1:0]     row_idx_q;
  logic [ROWS-1:0]   row_q;
  logic [CW-1:0]     col_idx_q;
  logic [DW-1:0]     div_q;
  logic [BW-1:0]     deb_q;
  logic              key_held_q;
  logic              push_q;
  logic [CODE_W-1:0] push_code_q;
`ifdef KEYPAD_TYPEMATIC_EN
  logic [TW-1:0]     rep_q;
`endif

  logic [CW-1:0]     low_col_d;
  logic [COLS-1:0]   col_onehot_d;
  logic [RW-1:0]     next_row_d;
  logic [CODE_W-1:0] cur_code_d;

  // When several columns are active, the lowest-numbered column wins.
  always_comb begin
    low_col_d = '0;
    for (int c = COLS-1; c >= 0; c--) begin
      if (col_s_q[c]) low_col_d = CW'(c);
    end
  end

  assign col_onehot_d = COLS'(1) << col_idx_q;
  assign next_row_d   = (row_idx_q == RW'(ROWS-1)) ? '0 : row_idx_q + RW'(1);
  assign cur_code_d   = CODE_W'(int'(row_idx_q) * COLS + int'(col_idx_q));

  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_idx_q   <= '0;
      row_q       <= ROWS'(1);
      col_idx_q   <= '0;
      div_q       <= '0;
      deb_q       <= '0;
      key_held_q  <= 1'b0;
      push_q      <= 1'b0;
      push_code_q <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_q       <= '0;
`endif
    end else begin
      row_q       <= ROWS'(1) << row_idx_q;
      push_q      <= 1'b0;
      push_code_q <= cur_code_d;
      case (state_q)
        ST_SCAN: begin
          if (div_q >= DW'(SETTLE_CYC) && col_s_q != '0) begin
            col_idx_q <= low_col_d;
            deb_q     <= '0;
            state_q   <= ST_DEB_PRESS;
          end else if (div_q == DW'(SCAN_DIV-1)) begin
            div_q     <= '0;
            row_idx_q <= next_row_d;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        ST_DEB_PRESS: begin
          if (col_s_q != col_onehot_d) begin
            // A bounce restarts the dwell on the same row.
            div_q   <= '0;
            state_q <= ST_SCAN;
          end else if (deb_q == BW'(DEBOUNCE_CYC-1)) begin
            push_q     <= 1'b1;
            key_held_q <= 1'b1;
            state_q    <= ST_HELD;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_q      <= '0;
`endif
          end else begin
            deb_q <= deb_q + BW'(1);
          end
        end
        ST_HELD: begin
          if (col_s_q == '0) begin
            deb_q   <= '0;
            state_q <= ST_DEB_REL;
          end
`ifdef KEYPAD_TYPEMATIC_EN
          else if (rep_q == TW'(REP_FIRST)) begin
            // Reloading to REP_RELOAD makes every later repeat 16*DEBOUNCE_CYC apart.
            push_q <= 1'b1;
            rep_q  <= TW'(REP_RELOAD);
          end else begin
            rep_q <= rep_q + TW'(1);
          end
`endif
        end
        ST_DEB_REL: begin
          if (col_s_q != '0) begin
            state_q <= ST_HELD;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_q   <= '0;
`endif
          end else if (deb_q == BW'(DEBOUNCE_CYC-1)) begin
            key_held_q <= 1'b0;
            div_q      <= '0;
            row_idx_q  <= next_row_d;
            state_q    <= ST_SCAN;
          end else begin
            deb_q <= deb_q + BW'(1);
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  // Key-code FIFO
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              ovf_q;
  logic              full_d, pop_d, push_ok_d;

  assign full_d    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop_d     = key_ready && (cnt_q != '0);
  // If the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign push_ok_d = push_q && (!full_d || pop_d);

  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok_d) begin
        mem_q[wr_ptr_q] <= push_code_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_d) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok_d, pop_d})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_q && !push_ok_d) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  assign row_o     = row_q;
  assign key_code  = mem_q[rd_ptr_q];
  assign key_valid = (cnt_q != '0);
  assign overflow  = ovf_q;
  assign key_held  = key_held_q;

endmodule
